// File: rtl/dsp_mem_capture_ctrl_if.sv
// Handshake/config/status bundle between the scan/config side and the
// capture sequencer. Timeout fields exist only with DSP_MEM_CAP_TIMEOUT_EN.
interface dsp_mem_capture_ctrl_if #(
    parameter int NumBanks     = 4,
    parameter int BankDepth    = 16,
    parameter int DelayWidth   = 16,
    parameter int BankIdxWidth = $clog2(NumBanks + 1)
`ifdef DSP_MEM_CAP_TIMEOUT_EN
    ,
    parameter int TimeoutWidth = 20
`endif
);
    logic                         i_start;
    logic                         i_abort;
    logic                         i_trig;
    logic                         i_cfg_sw_trig;
    logic [DelayWidth-1:0]        i_cfg_trig_delay;
    logic [BankIdxWidth-1:0]      i_cfg_num_banks;
    logic [NumBanks-1:0]          o_wshift;
    logic                         o_busy;
    logic                         o_done;
    logic [BankIdxWidth-1:0]      o_bank_idx;
    logic [$clog2(BankDepth)-1:0] o_word_cnt;
    logic [2:0]                   o_state;
`ifdef DSP_MEM_CAP_TIMEOUT_EN
    logic [TimeoutWidth-1:0]      i_cfg_timeout;
    logic                         o_timed_out;
`endif

    modport master (
        output i_start, i_abort, i_trig,
        output i_cfg_sw_trig, i_cfg_trig_delay, i_cfg_num_banks,
`ifdef DSP_MEM_CAP_TIMEOUT_EN
        output i_cfg_timeout,
        input  o_timed_out,
`endif
        input  o_wshift, o_busy, o_done,
        input  o_bank_idx, o_word_cnt, o_state
    );

    modport slave (
        input  i_start, i_abort, i_trig,
        input  i_cfg_sw_trig, i_cfg_trig_delay, i_cfg_num_banks,
`ifdef DSP_MEM_CAP_TIMEOUT_EN
        input  i_cfg_timeout,
        output o_timed_out,
`endif
        output o_wshift, o_busy, o_done,
        output o_bank_idx, o_word_cnt, o_state
    );
endinterface

// File: rtl/dsp_mem_capture_ctrl.sv
// Write-side capture sequencer: arm, trigger, delay, then fill banks in turn.
// Optional ARMED timeout is enabled by defining DSP_MEM_CAP_TIMEOUT_EN.
module dsp_mem_capture_ctrl #(
    parameter int NumBanks     = 4,
    parameter int BankDepth    = 16,
    parameter int DelayWidth   = 16,
    parameter int BankIdxWidth = $clog2(NumBanks + 1)
`ifdef DSP_MEM_CAP_TIMEOUT_EN
    ,
    parameter int TimeoutWidth = 20
`endif
) (
    input  logic                    i_wclk,
    input  logic                    rst_sync_write,
    dsp_mem_capture_ctrl_if.slave   bus
);
    localparam int WcW = $clog2(BankDepth);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_sw_trig;
    logic [DelayWidth-1:0]   r_delay;
    logic [BankIdxWidth-1:0] r_num_banks;
    logic [DelayWidth-1:0]   r_dly_cnt;
    logic [DelayWidth-1:0]   w_dly_nxt;
    logic [BankIdxWidth-1:0] r_bank_idx;
    logic [BankIdxWidth-1:0] w_bank_nxt;
    logic [WcW-1:0]          r_word_cnt;
    logic [WcW-1:0]          w_word_nxt;
    logic [NumBanks-1:0]     r_wshift;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_arm;
    logic                    w_trig;
    logic [BankIdxWidth-1:0] w_nb_clamp;

`ifdef DSP_MEM_CAP_TIMEOUT_EN
    logic [TimeoutWidth-1:0] r_timeout;
    logic [TimeoutWidth-1:0] r_to_cnt;
    logic [TimeoutWidth-1:0] w_to_nxt;
    logic                    r_timed_out;
    logic                    w_to_hit;

    // timeout fires only while ARMED and only when a nonzero limit was latched
    always_comb begin
        w_to_hit = (r_state == S_ARMED) && (r_timeout != '0)
                   && (r_to_cnt == r_timeout);
        w_trig   = bus.i_trig | r_sw_trig | w_to_hit;
    end
`else
    // ARMED waits indefinitely for the external or software trigger
    always_comb begin
        w_trig = bus.i_trig | r_sw_trig;
    end
`endif

    // bank count 0 behaves as 1; larger than NumBanks saturates
    always_comb begin
        w_nb_clamp = bus.i_cfg_num_banks;
        if (bus.i_cfg_num_banks == '0)
            w_nb_clamp = BankIdxWidth'(1);
        else if (bus.i_cfg_num_banks > BankIdxWidth'(NumBanks))
            w_nb_clamp = BankIdxWidth'(NumBanks);
    end

    // next-state and counter update; abort overrides every state
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly_cnt;
        w_bank_nxt  = r_bank_idx;
        w_word_nxt  = r_word_cnt;
        w_arm       = 1'b0;
`ifdef DSP_MEM_CAP_TIMEOUT_EN
        w_to_nxt    = '0;
`endif
        if (bus.i_abort) begin
            w_state_nxt = S_IDLE;
            w_dly_nxt   = '0;
            w_bank_nxt  = '0;
            w_word_nxt  = '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.i_start) begin
                        w_state_nxt = S_ARMED;
                        w_arm       = 1'b1;
                    end
                end
                S_ARMED: begin
`ifdef DSP_MEM_CAP_TIMEOUT_EN
                    w_to_nxt = r_to_cnt + TimeoutWidth'(1);
`endif
                    if (w_trig) begin
                        w_bank_nxt = '0;
                        w_word_nxt = '0;
                        w_dly_nxt  = '0;
                        if (r_delay == '0)
                            w_state_nxt = S_CAPTURE;
                        else
                            w_state_nxt = S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (r_dly_cnt == r_delay - DelayWidth'(1)) begin
                        w_state_nxt = S_CAPTURE;
                        w_dly_nxt   = '0;
                    end else begin
                        w_dly_nxt = r_dly_cnt + DelayWidth'(1);
                    end
                end
                S_CAPTURE: begin
                    if (r_word_cnt == WcW'(BankDepth - 1)) begin
                        w_word_nxt = '0;
                        if (r_bank_idx + BankIdxWidth'(1) >= r_num_banks) begin
                            w_state_nxt = S_DONE;
                            w_bank_nxt  = '0;
                        end else begin
                            w_bank_nxt = r_bank_idx + BankIdxWidth'(1);
                        end
                    end else begin
                        w_word_nxt = r_word_cnt + WcW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // state register; reset drops everything asynchronously
    always_ff @(posedge i_wclk or posedge rst_sync_write) begin
        if (rst_sync_write)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // counters and registered outputs derived from the next state
    always_ff @(posedge i_wclk or posedge rst_sync_write) begin
        if (rst_sync_write) begin
            r_dly_cnt  <= '0;
            r_bank_idx <= '0;
            r_word_cnt <= '0;
            r_wshift   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_dly_cnt  <= w_dly_nxt;
            r_bank_idx <= w_bank_nxt;
            r_word_cnt <= w_word_nxt;
            r_wshift   <= (w_state_nxt == S_CAPTURE)
                          ? (NumBanks'(1) << w_bank_nxt) : '0;
            r_busy     <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_DELAY)
                          || (w_state_nxt == S_CAPTURE);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    // configuration snapshot taken only on the arming edge
    always_ff @(posedge i_wclk or posedge rst_sync_write) begin
        if (rst_sync_write) begin
            r_sw_trig   <= 1'b0;
            r_delay     <= '0;
            r_num_banks <= '0;
        end else if (w_arm) begin
            r_sw_trig   <= bus.i_cfg_sw_trig;
            r_delay     <= bus.i_cfg_trig_delay;
            r_num_banks <= w_nb_clamp;
        end
    end

`ifdef DSP_MEM_CAP_TIMEOUT_EN
    // ARMED cycle counter and sticky timeout flag
    always_ff @(posedge i_wclk or posedge rst_sync_write) begin
        if (rst_sync_write) begin
            r_timeout   <= '0;
            r_to_cnt    <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_to_cnt <= w_to_nxt;
            if (w_arm)
                r_timeout <= bus.i_cfg_timeout;
            if (bus.i_abort || w_arm)
                r_timed_out <= 1'b0;
            else if (w_to_hit && !(bus.i_trig || r_sw_trig))
                r_timed_out <= 1'b1;
        end
    end

    assign bus.o_timed_out = r_timed_out;
`endif

    assign bus.o_wshift   = r_wshift;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_bank_idx = r_bank_idx;
    assign bus.o_word_cnt = r_word_cnt;
    assign bus.o_state    = r_state;
endmodule

// File: doc/dsp_mem_capture_ctrl.md
Name: dsp_mem_capture_ctrl

Overview:
Write-side capture sequencer for a row of dsp_mem_bank instances sharing one write clock. It arms on a start pulse, waits for a trigger plus a programmable post-trigger delay, then asserts the write-shift mode of each selected bank in turn for exactly BankDepth cycles, filling the banks back-to-back. It sits between the scan/config interface and the banks' i_cfg_mode_wshift inputs, entirely in the i_wclk domain.

Parameters:
NumBanks, 4, number of banks sequenced (>=1)
BankDepth, 16, shift cycles per bank; equals the bank depth
DelayWidth, 16, width of the post-trigger delay configuration
BankIdxWidth, $clog2(NumBanks+1), width of bank count/index fields

Ports:
i_wclk  input  1  write clock, shared with the banks
rst_sync_write  input  1  reset, asynchronous, active-high; clock i_wclk
i_start  input  1  arm request, single-cycle pulse
i_abort  input  1  abort request, level or pulse
i_trig  input  1  external capture trigger, synchronous to i_wclk
i_cfg_sw_trig  input  1  1 = trigger immediately on arming; i_trig ignored
i_cfg_trig_delay  input  DelayWidth  cycles between trigger and first shift
i_cfg_num_banks  input  BankIdxWidth  banks to fill, starting at bank 0
o_wshift  output  NumBanks  per-bank write-shift enable (to i_cfg_mode_wshift)
o_busy  output  1  high in ARMED, DELAY, CAPTURE
o_done  output  1  high in DONE
o_bank_idx  output  BankIdxWidth  bank currently shifting
o_word_cnt  output  $clog2(BankDepth)  shift cycle within the current bank
o_state  output  3  encoded state: IDLE=0 ARMED=1 DELAY=2 CAPTURE=3 DONE=4

Behaviour:
- Reset: state IDLE. o_wshift=0, o_busy=0, o_done=0, o_bank_idx=0, o_word_cnt=0, delay counter=0. All outputs are registered.
- Config is latched on arming (IDLE/DONE -> ARMED). Config changes after arming have no effect until the next arm.
- num_banks=0 is treated as 1. Values greater than NumBanks are clamped to NumBanks.
- IDLE: i_start -> ARMED on the next edge.
- ARMED: trigger = i_trig | latched sw_trig.
  - Trigger with delay=0 -> CAPTURE.
  - Trigger with delay=D>0 -> DELAY.
  - With sw_trig set, ARMED lasts exactly 1 cycle.
- DELAY: counts D cycles, then -> CAPTURE. Exactly D cycles elapse in DELAY.
- CAPTURE:
  - o_wshift is one-hot at bit o_bank_idx. o_word_cnt increments every cycle.
  - At word_cnt=BankDepth-1: word_cnt wraps to 0 and bank_idx increments. The next bank's bit goes high on the following cycle with no gap, so bank k has its wshift high for exactly BankDepth consecutive cycles.
  - After the last selected bank completes: -> DONE, o_wshift=0 on that edge, bank_idx reset to 0.
- Trigger-to-shift latency: trigger sampled at edge n gives o_wshift[0] high from edge n+1+D. Downstream banks add one further sync cycle internally; aligning the data path to that cycle is outside this block.
- DONE: o_done held high. i_start re-arms (-> ARMED) and clears o_done on the same edge.
- i_start while busy: ignored.
- i_trig outside ARMED: ignored. Triggers are not queued.
- i_abort: highest priority in every state. Next edge goes to IDLE and clears all counters and o_wshift. Bank contents are left as partially written. Abort and start on the same cycle resolves to abort.
- Reset mid-capture: o_wshift drops asynchronously with reset assertion.

Optional Feature:
Macro: DSP_MEM_CAP_TIMEOUT_EN
- Defined:
  - Adds parameter TimeoutWidth (default 20), input i_cfg_timeout[TimeoutWidth], and output o_timed_out.
  - In ARMED, a counter increments each cycle. On reaching i_cfg_timeout (nonzero) with no trigger, the controller forces a trigger and sets o_timed_out.
  - o_timed_out is sticky until the next arm, abort or reset. A value of 0 disables the timeout.
- Not defined: the port and counter are absent, and ARMED waits indefinitely.

Test Plan:
- Reset asserted mid-CAPTURE (NumBanks=4, BankDepth=16) -> o_wshift=0 and state=0 immediately; after deassertion, outputs stay at reset values until i_start.
- sw_trig=1, delay=0, num_banks=4 -> o_wshift sequence 0001 x16, 0010 x16, 0100 x16, 1000 x16 with no gap, starting 2 cycles after i_start. o_done rises on cycle 66 after i_start.
- sw_trig=0, delay=5, num_banks=2, i_trig pulsed 10 cycles after arm -> o_wshift[0] rises 6 cycles after the trigger edge. Exactly 32 shift cycles, banks 2-3 never enabled.
- num_banks=0 -> exactly 16 shift cycles on bank 0. num_banks=7 -> exactly 64 shift cycles (clamped to 4 banks).
- i_abort at bank 1, word 9 -> o_wshift=0 next cycle, state=IDLE, o_done=0. i_start during CAPTURE is ignored (cycle count unchanged). i_trig in IDLE or DONE causes no shift.
- With DSP_MEM_CAP_TIMEOUT_EN, timeout=100, no i_trig -> capture starts 101 cycles after arming and o_timed_out=1. An i_trig at cycle 50 -> o_timed_out stays 0.
